// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-ported, variable-latency unified memory between the
// instruction-fetch requester (i_*) and the load/store requester (d_*).
// One transaction is in flight at a time. A requester stalls while its req
// is high and its ack is low. A watchdog aborts any memory transaction that
// waits TIMEOUT grant cycles without m_ready.
//
// Configuration macro:
//   MEMARB_RR_EN  defined   -> round-robin between the two ports on contention
//                 undefined -> fixed priority, data over fetch (default)
//
// Parameters:
//   AW        address width
//   DW        data width
//   TIMEOUT   grant cycles without m_ready before abort (1..255)
//   ERR_DATA  read data returned by an aborted load or fetch
//
// Ports:
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   i_req, i_addr         fetch request (held until i_ack) and address
//   i_rdata, i_ack        fetch read data, one-cycle completion pulse
//   d_req, d_we, d_addr,  data request (held until d_ack), write enable,
//   d_wdata               address and store data
//   d_rdata, d_ack        load data, one-cycle completion pulse
//   m_req, m_we, m_addr,  memory request side, held stable during a grant
//   m_wdata
//   m_rdata, m_ready      memory read data and completion
//   busy                  a transaction is in progress
//   timeout_err           sticky, set by any aborted transaction
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned     AW       = 32,
    parameter int unsigned     DW       = 32,
    parameter int unsigned     TIMEOUT  = 15,
    parameter logic [DW-1:0]   ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic          clk,
    input  logic          reset,
    // fetch port
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ack,
    // data port
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ack,
    // memory side
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ready,
    // status
    output logic          busy,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    typedef enum logic {
        PORT_I = 1'b0,
        PORT_D = 1'b1
    } port_t;

`ifdef MEMARB_RR_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    // Last grant-cycle index before the watchdog fires.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    port_t      last_grant;
    logic [7:0] wait_cnt;

    logic i_cand;
    logic d_cand;
    logic pick_d;
    logic pick_i;

    // A port whose ack is high this cycle is masked, giving its requester one
    // cycle to drop or replace the request before it can be granted again.
    assign i_cand = i_req & ~i_ack;
    assign d_cand = d_req & ~d_ack;

    // Data wins unless round-robin is enabled, both contend, and data was the
    // most recent grant.
    assign pick_d = d_cand & (~i_cand | ~RR_EN | (last_grant == PORT_I));
    assign pick_i = i_cand & ~pick_d;

    // NOTE: all state and registered outputs update with non-blocking
    // assignments in one clocked block, so every branch reads the values from
    // before the edge and the default ack clear below is simply overridden.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            last_grant  <= PORT_I;
            wait_cnt    <= '0;
            m_req       <= 1'b0;
            m_we        <= 1'b0;
            m_addr      <= '0;
            m_wdata     <= '0;
            i_rdata     <= '0;
            i_ack       <= 1'b0;
            d_rdata     <= '0;
            d_ack       <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Acks are single-cycle pulses.
            i_ack <= 1'b0;
            d_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (pick_d) begin
                        state      <= GRANT_D;
                        last_grant <= PORT_D;
                        wait_cnt   <= '0;
                        m_req      <= 1'b1;
                        busy       <= 1'b1;
                        m_addr     <= d_addr;
                        m_we       <= d_we;
                        m_wdata    <= d_wdata;
                    end else if (pick_i) begin
                        state      <= GRANT_I;
                        last_grant <= PORT_I;
                        wait_cnt   <= '0;
                        m_req      <= 1'b1;
                        busy       <= 1'b1;
                        m_addr     <= i_addr;
                        m_we       <= 1'b0;
                    end
                end

                GRANT_I, GRANT_D: begin
                    // m_ready wins over the watchdog when both land together.
                    if (m_ready || (wait_cnt == WAIT_LAST)) begin
                        state <= IDLE;
                        m_req <= 1'b0;
                        busy  <= 1'b0;
                        if (!m_ready) begin
                            timeout_err <= 1'b1;
                        end
                        if (state == GRANT_I) begin
                            i_ack   <= 1'b1;
                            i_rdata <= m_ready ? m_rdata : ERR_DATA;
                        end else begin
                            d_ack <= 1'b1;
                            // Stores leave the load-data register untouched.
                            if (!m_we) begin
                                d_rdata <= m_ready ? m_rdata : ERR_DATA;
                            end
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                default: begin
                    state <= IDLE;
                    m_req <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Drives both requesters and a memory responder with randomized traffic and
// compares the arbiter against a transaction-level reference: each grant is
// a transaction with a chosen memory latency; it ends either on the cycle
// after the memory answers or after TIMEOUT grant cycles, and the matching
// ack, read data and error flag follow from that outcome. Directed phases
// cover the single fetch, contention, store, timeout, reset during a grant
// and alternating service under continuous contention.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int          TIMEOUT  = 15;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

`ifdef MEMARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic        m_ready;
    logic        busy;
    logic        timeout_err;

    mem_port_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .i_req       (i_req),
        .i_addr      (i_addr),
        .i_rdata     (i_rdata),
        .i_ack       (i_ack),
        .d_req       (d_req),
        .d_we        (d_we),
        .d_addr      (d_addr),
        .d_wdata     (d_wdata),
        .d_rdata     (d_rdata),
        .d_ack       (d_ack),
        .m_req       (m_req),
        .m_we        (m_we),
        .m_addr      (m_addr),
        .m_wdata     (m_wdata),
        .m_rdata     (m_rdata),
        .m_ready     (m_ready),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- memory contents ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- reference model state ----------------
    bit          mdl_busy;
    bit          mdl_is_d;
    bit          mdl_we;
    logic [31:0] mdl_addr;
    logic [31:0] mdl_wdata;
    int          mdl_k;       // index of the current grant cycle
    int          mdl_lat;     // grant cycle on which memory answers
    bit          last_d;      // most recent grant went to data
    bit          exp_i_ack, exp_d_ack, exp_terr;
    logic [31:0] exp_i_rdata, exp_d_rdata, exp_maddr;
    bit          exp_mwe;
    int          forced_lat = -1;

    // values present at the upcoming clock edge
    bit          prev_i_req, prev_d_req, prev_i_ack, prev_d_ack, prev_m_ready;
    logic [31:0] prev_m_rdata;

    // requester behaviour knobs
    bit auto_i, auto_d, keep_i, keep_d;

    task automatic model_reset();
        mdl_busy    = 1'b0;
        last_d      = 1'b0;
        exp_i_ack   = 1'b0;
        exp_d_ack   = 1'b0;
        exp_terr    = 1'b0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        exp_maddr   = '0;
        exp_mwe     = 1'b0;
        m_ready     = 1'b0;
        m_rdata     = '0;
    endtask

    function automatic int pick_latency();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return int'($urandom_range(0, 3));
        if (r < 8) return int'($urandom_range(4, TIMEOUT - 2));
        if (r == 8) return TIMEOUT - 1;   // answer on the watchdog's last cycle
        return 255;                        // never answers
    endfunction

    // One clock cycle: advance the reference, compare, then drive the memory
    // responder and the requesters for the next edge.
    task automatic step();
        bit cand_i, cand_d, win_d;
        prev_i_req   = i_req;
        prev_d_req   = d_req;
        prev_i_ack   = exp_i_ack;
        prev_d_ack   = exp_d_ack;
        prev_m_ready = m_ready;
        prev_m_rdata = m_rdata;

        @(posedge clk);
        #1;

        exp_i_ack = 1'b0;
        exp_d_ack = 1'b0;
        if (mdl_busy) begin
            if (prev_m_ready || mdl_k == TIMEOUT - 1) begin
                if (mdl_is_d) begin
                    exp_d_ack = 1'b1;
                    if (!mdl_we) exp_d_rdata = prev_m_ready ? prev_m_rdata : ERR_DATA;
                end else begin
                    exp_i_ack   = 1'b1;
                    exp_i_rdata = prev_m_ready ? prev_m_rdata : ERR_DATA;
                end
                if (!prev_m_ready) exp_terr = 1'b1;
                if (prev_m_ready && mdl_we) mem[mdl_addr] = mdl_wdata;
                mdl_busy = 1'b0;
            end else begin
                mdl_k++;
            end
        end else begin
            cand_i = prev_i_req && !prev_i_ack;
            cand_d = prev_d_req && !prev_d_ack;
            if (cand_i || cand_d) begin
                if (cand_i && cand_d) win_d = RR ? !last_d : 1'b1;
                else                  win_d = cand_d;
                mdl_busy  = 1'b1;
                mdl_is_d  = win_d;
                mdl_k     = 0;
                last_d    = win_d;
                mdl_addr  = win_d ? d_addr : i_addr;
                mdl_we    = win_d ? d_we : 1'b0;
                mdl_wdata = d_wdata;
                exp_maddr = mdl_addr;
                exp_mwe   = mdl_we;
                if (forced_lat >= 0) begin
                    mdl_lat    = forced_lat;
                    forced_lat = -1;
                end else begin
                    mdl_lat = pick_latency();
                end
            end
        end

        check("m_req", m_req, mdl_busy);
        check("busy", busy, mdl_busy);
        check("i_ack", i_ack, exp_i_ack);
        check("d_ack", d_ack, exp_d_ack);
        check("i_rdata", i_rdata, exp_i_rdata);
        check("d_rdata", d_rdata, exp_d_rdata);
        check("timeout_err", timeout_err, exp_terr);
        check("m_addr", m_addr, exp_maddr);
        check("m_we", m_we, exp_mwe);
        if (mdl_busy && mdl_is_d) check("m_wdata", m_wdata, mdl_wdata);

        // memory responder; m_rdata is junk except when answering a read
        if (mdl_busy && mdl_k == mdl_lat) begin
            m_ready = 1'b1;
            m_rdata = mdl_we ? $urandom : mem_rd(mdl_addr);
        end else begin
            m_ready = 1'b0;
            m_rdata = $urandom;
        end

        // requesters
        if (exp_i_ack && !keep_i) i_req = 1'b0;
        if (exp_d_ack && !keep_d) d_req = 1'b0;
        if (auto_i && !i_req && $urandom_range(0, 2) == 0) begin
            i_req  = 1'b1;
            i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        end
        if (auto_d && !d_req && $urandom_range(0, 2) == 0) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            d_wdata = $urandom;
        end
    endtask

    // Step until both requesters are served and the arbiter is idle.
    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((i_req || d_req || mdl_busy) && n < 80) begin
            step();
            n++;
        end
        check({tag, "_completed"}, {31'd0, (i_req || d_req || mdl_busy)}, 32'd0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got no end expected end");
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [31:0] order [4];
        int          got;
        int          n;
        bit          was_req;

        reset   = 1'b1;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        auto_i  = 1'b0;
        auto_d  = 1'b0;
        keep_i  = 1'b0;
        keep_d  = 1'b0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        check("reset_m_req", m_req, 32'd0);
        check("reset_busy", busy, 32'd0);
        check("reset_acks", {30'd0, i_ack, d_ack}, 32'd0);
        check("reset_terr", timeout_err, 32'd0);
        check("reset_m_addr", m_addr, 32'd0);
        check("reset_i_rdata", i_rdata, 32'd0);
        reset = 1'b0;
        step();

        // single fetch, memory answers on the first grant cycle
        mem[32'h40] = 32'h8C01_0004;
        forced_lat  = 0;
        i_addr      = 32'h40;
        i_req       = 1'b1;
        drain("fetch");
        check("fetch_rdata", i_rdata, 32'h8C01_0004);

        // contention: data is served first, fetch follows in the ack cycle
        d_addr = 32'h10;
        d_we   = 1'b0;
        d_req  = 1'b1;
        i_addr = 32'h44;
        i_req  = 1'b1;
        drain("contend");

        // store answered after three wait cycles
        forced_lat = 3;
        d_we       = 1'b1;
        d_addr     = 32'h20;
        d_wdata    = 32'h1234_5678;
        d_req      = 1'b1;
        drain("store");

        // load with no answer from memory
        forced_lat = 255;
        d_we       = 1'b0;
        d_addr     = 32'h24;
        d_req      = 1'b1;
        drain("timeout");
        check("timeout_rdata", d_rdata, ERR_DATA);
        check("timeout_sticky", timeout_err, 32'd1);

        // reset while a grant is outstanding
        forced_lat = 255;
        d_we       = 1'b0;
        d_addr     = 32'h30;
        d_req      = 1'b1;
        repeat (4) step();
        #2 reset = 1'b1;
        #1;
        check("rst_async_m_req", m_req, 32'd0);
        check("rst_async_busy", busy, 32'd0);
        check("rst_async_terr", timeout_err, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_no_ack", {30'd0, i_ack, d_ack}, 32'd0);
        model_reset();
        reset      = 1'b0;
        forced_lat = 1;
        drain("rst_retry");

        // both requesters held continuously: service alternates D, I, D, I
        i_addr  = 32'h100;
        d_addr  = 32'h200;
        d_we    = 1'b0;
        keep_i  = 1'b1;
        keep_d  = 1'b1;
        i_req   = 1'b1;
        d_req   = 1'b1;
        got     = 0;
        n       = 0;
        was_req = m_req;
        while (got < 4 && n < 200) begin
            step();
            if (m_req && !was_req) begin
                order[got] = m_addr;
                got++;
            end
            was_req = m_req;
            n++;
        end
        check("alt_grants", got, 32'd4);
        check("alt_order0", order[0], 32'h200);
        check("alt_order1", order[1], 32'h100);
        check("alt_order2", order[2], 32'h200);
        check("alt_order3", order[3], 32'h100);
        keep_i = 1'b0;
        keep_d = 1'b0;
        drain("alt");

        // randomized traffic on both ports
        auto_i = 1'b1;
        auto_d = 1'b1;
        repeat (3000) step();
        auto_i = 1'b0;
        auto_d = 1'b0;
        drain("random");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency unified memory between the pipeline's instruction-fetch requester and its data (load/store) requester.
- Sits between the fetch/memory stages and the memory model.
- Serialises accesses through a small FSM, returns registered read data with a one-cycle ack, and applies a watchdog timeout to memory transactions.
- The pipeline stalls on a requester whenever that requester's req is high and its ack is low.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- TIMEOUT, 15, maximum number of GRANT cycles without m_ready before the transaction is aborted (valid range 1..255).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on an aborted transaction.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  fetch request; held high until i_ack.
- i_addr  in  AW  fetch address.
- i_rdata  out  DW  fetch read data; valid when i_ack is high.
- i_ack  out  1  one-cycle fetch completion pulse.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  data write enable.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rdata  out  DW  load data; valid when d_ack is high.
- d_ack  out  1  one-cycle data completion pulse.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data; valid with m_ready.
- m_ready  in  1  memory completion.
- busy  out  1  high when state is not IDLE.
- timeout_err  out  1  sticky flag, set on any abort.

Behaviour:
- Reset is asynchronous and active-high; clock is clk.
  - Reset values: state IDLE, every output 0, wait counter 0, last_grant = I.
  - Reset asserted mid-transaction drops m_req immediately. No ack is issued for the aborted transaction.
- States and transitions:
  - IDLE:
    - Sample i_req and d_req.
    - Choose a winner: data wins by default; round-robin when MEMARB_RR_EN is defined.
    - Register the winner's address, write enable and write data into m_addr, m_we and m_wdata. A fetch always drives m_we = 0.
    - Go to GRANT_I or GRANT_D, set last_grant, clear the wait counter.
    - With no request, stay in IDLE.
  - GRANT_I / GRANT_D:
    - m_req = 1; m_addr, m_we and m_wdata are held stable from the registers.
    - If m_ready = 1: latch m_rdata into i_rdata or d_rdata (load or fetch only), assert the matching ack on the next cycle, and go to IDLE.
    - Else if the wait counter equals TIMEOUT-1: load ERR_DATA into the rdata register (load or fetch only), set timeout_err, assert the matching ack on the next cycle, and go to IDLE.
    - Else increment the wait counter.
- Ack timing and latency:
  - An ack rises in the same cycle that the state returns to IDLE. It is registered and lasts exactly one cycle.
  - Minimum latency: request seen in IDLE at cycle N, GRANT at N+1 with m_ready = 1, ack at N+2.
- Ack-cycle masking:
  - In the IDLE cycle where an ack is high, the acked port's req is masked, so the requester has one cycle to drop or change its request.
  - The other port may win arbitration in that same cycle.
- Write handling:
  - d_rdata keeps its previous value on a store, including a store that is aborted.
  - m_rdata is ignored on writes.
- Registered outputs:
  - i_rdata and d_rdata hold their value until the next completion on their own port.
  - m_addr, m_we and m_wdata hold their value in IDLE; m_req = 0 in IDLE.
- Width rules: the wait counter is 8 bits and saturates at TIMEOUT-1.
- Simultaneous events:
  - m_ready arriving in the same cycle the counter reaches TIMEOUT-1 counts as a normal completion; no error is raised.
  - Changes on req inputs during GRANT are ignored.

Optional Feature:
- Macro: MEMARB_RR_EN.
- Defined: when both requests are high in IDLE, grant the port opposite to last_grant. Since last_grant resets to I, the first contention after reset goes to data.
- Undefined: fixed priority, data over fetch. last_grant is still tracked but unused.

Test Plan:
- Fetch only:
  - Stimulus: i_req = 1, i_addr = 0x40, memory returns 0x8C010004 with m_ready one cycle after m_req.
  - Response: m_addr = 0x40, m_we = 0; i_ack pulses at cycle N+2 with i_rdata = 0x8C010004; busy low afterwards.
- Contention, fixed priority:
  - Stimulus: i_req and d_req raised in the same cycle, d_addr = 0x10, d_we = 0.
  - Response: data served first; fetch granted in the ack cycle of the data transaction; i_ack arrives after d_ack.
- Store:
  - Stimulus: d_we = 1, d_addr = 0x20, d_wdata = 0x12345678, m_ready after 3 wait cycles.
  - Response: m_we = 1 and m_wdata = 0x12345678 held for 4 cycles; d_ack pulses once; d_rdata unchanged.
- Timeout:
  - Stimulus: m_ready held low on a load.
  - Response: m_req stays high for exactly 15 cycles; then d_ack pulses with d_rdata = 0xDEADBEEF; timeout_err goes high and stays high until reset.
- Reset mid-GRANT:
  - Stimulus: reset asserted asynchronously while m_req = 1.
  - Response: m_req and busy go to 0 immediately; no ack is issued; the next request proceeds normally.
- Round-robin, MEMARB_RR_EN defined:
  - Stimulus: both requesters held continuously for 4 transactions.
  - Response: grant order D, I, D, I.
